// File: rtl/otter_pipe_pkg.sv
// Shared decode-stage types for the two-lane Otter pipeline: issue FSM states
// and the per-slot register/usage bundle.
package otter_pipe_pkg;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    PAIR  = 2'd1,
    SPLIT = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_used;
    logic       rs2_used;
    logic       reg_write;
    logic       ctrl;
    logic       mem;
  } slot_info_t;

  // x0 is hardwired to zero, so a match on address 0 never forms a dependency.
  function automatic logic src_hits(input logic [4:0] src, input logic used,
                                    input logic [4:0] rd);
    return used && (src != 5'd0) && (src == rd);
  endfunction

endpackage

// File: rtl/otter_hazard_cmp.sv
// Load-use detector for one decode slot against both EX-stage lanes.
module otter_hazard_cmp
  import otter_pipe_pkg::*;
(
  input  slot_info_t slot_i,
  input  logic       ex_load0_i,
  input  logic       ex_load1_i,
  input  logic [4:0] ex_rd0_i,
  input  logic [4:0] ex_rd1_i,
  output logic       lu_o
);

  logic hit0;
  logic hit1;
  logic unused_fields;

  assign hit0 = src_hits(slot_i.rs1, slot_i.rs1_used, ex_rd0_i) ||
                src_hits(slot_i.rs2, slot_i.rs2_used, ex_rd0_i);
  assign hit1 = src_hits(slot_i.rs1, slot_i.rs1_used, ex_rd1_i) ||
                src_hits(slot_i.rs2, slot_i.rs2_used, ex_rd1_i);

  assign lu_o = (ex_load0_i && hit0) || (ex_load1_i && hit1);

  // Destination and class bits travel with the slot but play no part in load-use.
  assign unused_fields = ^{slot_i.rd, slot_i.reg_write, slot_i.ctrl, slot_i.mem};

endmodule

// File: rtl/otter_issue_ctrl.sv
// Dual-issue scheduler at decode: pair / split / stall / flush decisions.
// Optional perf counters are built when OTTER_ISSUE_PERF_EN is defined.
module otter_issue_ctrl
  import otter_pipe_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       de_valid,
  input  logic [4:0] s0_rs1,
  input  logic [4:0] s0_rs2,
  input  logic [4:0] s0_rd,
  input  logic       s0_rs1_used,
  input  logic       s0_rs2_used,
  input  logic       s0_reg_write,
  input  logic       s0_ctrl,
  input  logic       s0_mem,
  input  logic [4:0] s1_rs1,
  input  logic [4:0] s1_rs2,
  input  logic [4:0] s1_rd,
  input  logic       s1_rs1_used,
  input  logic       s1_rs2_used,
  input  logic       s1_reg_write,
  input  logic       s1_ctrl,
  input  logic       s1_mem,
  input  logic       ex_load0,
  input  logic       ex_load1,
  input  logic [4:0] ex_rd0,
  input  logic [4:0] ex_rd1,
  input  logic       ex_redirect,
  output logic       pc_write,
  output logic       ifde_write,
  output logic       issue0,
  output logic       issue1,
  output logic       split_active
`ifdef OTTER_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_pair,
  output logic [31:0] perf_split,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  issue_state_t state_q, state_d;
  slot_info_t   slot0, slot1;
  logic         lu0, lu1;
  logic         raw, waw, splitCond;

  assign slot0 = '{rs1: s0_rs1, rs2: s0_rs2, rd: s0_rd, rs1_used: s0_rs1_used,
                   rs2_used: s0_rs2_used, reg_write: s0_reg_write,
                   ctrl: s0_ctrl, mem: s0_mem};
  assign slot1 = '{rs1: s1_rs1, rs2: s1_rs2, rd: s1_rd, rs1_used: s1_rs1_used,
                   rs2_used: s1_rs2_used, reg_write: s1_reg_write,
                   ctrl: s1_ctrl, mem: s1_mem};

  otter_hazard_cmp u_cmp0 (
    .slot_i(slot0), .ex_load0_i(ex_load0), .ex_load1_i(ex_load1),
    .ex_rd0_i(ex_rd0), .ex_rd1_i(ex_rd1), .lu_o(lu0)
  );

  otter_hazard_cmp u_cmp1 (
    .slot_i(slot1), .ex_load0_i(ex_load0), .ex_load1_i(ex_load1),
    .ex_rd0_i(ex_rd0), .ex_rd1_i(ex_rd1), .lu_o(lu1)
  );

  // Intra-pair conflicts that force slot 1 to trail slot 0 by one cycle.
  assign raw = s0_reg_write && (src_hits(s1_rs1, s1_rs1_used, s0_rd) ||
                                src_hits(s1_rs2, s1_rs2_used, s0_rd));
  assign waw = s0_reg_write && s1_reg_write && (s0_rd != 5'd0) && (s0_rd == s1_rd);
  assign splitCond = raw || waw || (s0_mem && s1_mem) || s0_ctrl;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= FLUSH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (RESET || ex_redirect) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        FLUSH: state_d = PAIR;
        PAIR:  if (de_valid && !lu0 && splitCond) state_d = SPLIT;
        SPLIT: if (!lu1) state_d = PAIR;
        default: state_d = FLUSH;
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    ifde_write   = 1'b0;
    issue0       = 1'b0;
    issue1       = 1'b0;
    split_active = 1'b0;
    if (!RESET) begin
      split_active = (state_q == SPLIT);
      if (ex_redirect) begin
        pc_write   = 1'b1;
        ifde_write = 1'b1;
      end else begin
        case (state_q)
          PAIR: begin
            if (!de_valid) begin
              pc_write   = 1'b1;
              ifde_write = 1'b1;
            end else if (lu0 || (lu1 && !splitCond)) begin
              pc_write   = 1'b0;
            end else if (splitCond) begin
              issue0 = 1'b1;
            end else begin
              issue0     = 1'b1;
              issue1     = 1'b1;
              pc_write   = 1'b1;
              ifde_write = 1'b1;
            end
          end
          SPLIT: begin
            if (!lu1) begin
              issue1     = 1'b1;
              pc_write   = 1'b1;
              ifde_write = 1'b1;
            end
          end
          default: begin
            pc_write   = 1'b1;
            ifde_write = 1'b1;
          end
        endcase
      end
    end
  end

`ifdef OTTER_ISSUE_PERF_EN
  logic [31:0] pairCnt_q, splitCnt_q, stallCnt_q, flushCnt_q;
  logic        loadStall, splitEnter;

  assign loadStall  = !RESET && !ex_redirect &&
                      (((state_q == PAIR) && de_valid && (lu0 || (lu1 && !splitCond))) ||
                       ((state_q == SPLIT) && lu1));
  assign splitEnter = !RESET && !ex_redirect && (state_q == PAIR) &&
                      de_valid && !lu0 && splitCond;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pairCnt_q  <= '0;
      splitCnt_q <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (issue0 && issue1) pairCnt_q  <= pairCnt_q + 32'd1;
      if (splitEnter)       splitCnt_q <= splitCnt_q + 32'd1;
      if (loadStall)        stallCnt_q <= stallCnt_q + 32'd1;
      if (ex_redirect)      flushCnt_q <= flushCnt_q + 32'd1;
    end
  end

  assign perf_pair  = pairCnt_q;
  assign perf_split = splitCnt_q;
  assign perf_stall = stallCnt_q;
  assign perf_flush = flushCnt_q;
`endif

endmodule

// File: tb/tb_otter_issue_ctrl.sv
// Scoreboard bench for otter_issue_ctrl: directed pipeline scenarios followed by
// random traffic, checked against an event-level reference model.
module tb_otter_issue_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       w;
    logic       c;
    logic       m;
  } slot_t;

  typedef struct packed {
    logic        rst;
    logic        redir;
    logic        dv;
    slot_t [1:0] s;
    logic        exl0;
    logic        exl1;
    logic [4:0]  exrd0;
    logic [4:0]  exrd1;
  } vec_t;

  typedef struct packed {
    logic [4:0]  ctl;
    logic        chkPerf;
    logic [31:0] pPair;
    logic [31:0] pSplit;
    logic [31:0] pStall;
    logic [31:0] pFlush;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET, de_valid, ex_redirect, ex_load0, ex_load1;
  logic [4:0] s0_rs1, s0_rs2, s0_rd, s1_rs1, s1_rs2, s1_rd, ex_rd0, ex_rd1;
  logic       s0_rs1_used, s0_rs2_used, s0_reg_write, s0_ctrl, s0_mem;
  logic       s1_rs1_used, s1_rs2_used, s1_reg_write, s1_ctrl, s1_mem;
  logic       pc_write, ifde_write, issue0, issue1, split_active;
`ifdef OTTER_ISSUE_PERF_EN
  logic [31:0] perf_pair, perf_split, perf_stall, perf_flush;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t scoreQ[$];

  // Reference model: what the pipeline is waiting on, not how the FSM encodes it.
  bit          slot1Owed = 0;
  bit          staleFetch = 0;
  bit          countersKnown = 0;
  int unsigned nPair = 0, nSplit = 0, nStall = 0, nFlush = 0;

  always #5 CLK = ~CLK;

  otter_issue_ctrl dut (
    .CLK(CLK), .RESET(RESET), .de_valid(de_valid),
    .s0_rs1(s0_rs1), .s0_rs2(s0_rs2), .s0_rd(s0_rd),
    .s0_rs1_used(s0_rs1_used), .s0_rs2_used(s0_rs2_used),
    .s0_reg_write(s0_reg_write), .s0_ctrl(s0_ctrl), .s0_mem(s0_mem),
    .s1_rs1(s1_rs1), .s1_rs2(s1_rs2), .s1_rd(s1_rd),
    .s1_rs1_used(s1_rs1_used), .s1_rs2_used(s1_rs2_used),
    .s1_reg_write(s1_reg_write), .s1_ctrl(s1_ctrl), .s1_mem(s1_mem),
    .ex_load0(ex_load0), .ex_load1(ex_load1), .ex_rd0(ex_rd0), .ex_rd1(ex_rd1),
    .ex_redirect(ex_redirect),
    .pc_write(pc_write), .ifde_write(ifde_write),
    .issue0(issue0), .issue1(issue1), .split_active(split_active)
`ifdef OTTER_ISSUE_PERF_EN
    , .perf_pair(perf_pair), .perf_split(perf_split),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  function automatic bit reads(slot_t s, logic [4:0] r);
    return (r != 0) && ((s.u1 && s.rs1 == r) || (s.u2 && s.rs2 == r));
  endfunction

  function automatic bit loadUse(slot_t s, vec_t v);
    return (v.exl0 && reads(s, v.exrd0)) || (v.exl1 && reads(s, v.exrd1));
  endfunction

  function automatic bit mustSplit(vec_t v);
    slot_t a = v.s[0];
    slot_t b = v.s[1];
    return a.c || (a.m && b.m) || (a.w && reads(b, a.rd)) ||
           (a.w && b.w && a.rd != 0 && a.rd == b.rd);
  endfunction

  function automatic slot_t mk(int rs1, int rs2, int rd, bit u1, bit u2, bit w,
                               bit c, bit m);
    slot_t s;
    s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
    s.u1 = u1; s.u2 = u2; s.w = w; s.c = c; s.m = m;
    return s;
  endfunction

  function automatic vec_t blank();
    vec_t v = '0;
    v.dv = 1'b1;
    return v;
  endfunction

  // Drives one cycle of inputs, predicts the response and advances the model.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bit pc = 0, i0 = 0, i1 = 0, sa = 0;
    bit l0, l1, sp;
    @(posedge CLK);
    #1;
    RESET = v.rst; ex_redirect = v.redir; de_valid = v.dv;
    {s0_rs1, s0_rs2, s0_rd, s0_rs1_used, s0_rs2_used, s0_reg_write, s0_ctrl, s0_mem} = v.s[0];
    {s1_rs1, s1_rs2, s1_rd, s1_rs1_used, s1_rs2_used, s1_reg_write, s1_ctrl, s1_mem} = v.s[1];
    ex_load0 = v.exl0; ex_load1 = v.exl1; ex_rd0 = v.exrd0; ex_rd1 = v.exrd1;

    l0 = loadUse(v.s[0], v);
    l1 = loadUse(v.s[1], v);
    sp = mustSplit(v);
    e.chkPerf = countersKnown;
    e.pPair = nPair; e.pSplit = nSplit; e.pStall = nStall; e.pFlush = nFlush;

    if (v.rst) begin
      slot1Owed = 0; staleFetch = 1;
      nPair = 0; nSplit = 0; nStall = 0; nFlush = 0;
    end else begin
      sa = slot1Owed;
      if (v.redir) begin
        pc = 1; slot1Owed = 0; staleFetch = 1; nFlush++;
      end else if (staleFetch) begin
        pc = 1; staleFetch = 0;
      end else if (slot1Owed) begin
        if (l1) nStall++;
        else begin i1 = 1; pc = 1; slot1Owed = 0; end
      end else if (!v.dv) begin
        pc = 1;
      end else if (l0 || (l1 && !sp)) begin
        nStall++;
      end else if (sp) begin
        i0 = 1; slot1Owed = 1; nSplit++;
      end else begin
        i0 = 1; i1 = 1; pc = 1; nPair++;
      end
    end
    e.ctl = {pc, pc, i0, i1, sa};
    scoreQ.push_back(e);
    if (v.rst) countersKnown = 1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge CLK) begin
    if (scoreQ.size() > 0) begin
      exp_t e;
      e = scoreQ.pop_front();
      checkOutput("pc/ifde/i0/i1/split", {27'd0, pc_write, ifde_write, issue0, issue1,
                  split_active}, {27'd0, e.ctl});
`ifdef OTTER_ISSUE_PERF_EN
      if (e.chkPerf) begin
        checkOutput("perf_pair", perf_pair, e.pPair);
        checkOutput("perf_split", perf_split, e.pSplit);
        checkOutput("perf_stall", perf_stall, e.pStall);
        checkOutput("perf_flush", perf_flush, e.pFlush);
      end
`endif
    end
  end

  initial begin
    vec_t v;
    int   guard;
    RESET = 1; de_valid = 0; ex_redirect = 0; ex_load0 = 0; ex_load1 = 0;
    ex_rd0 = 0; ex_rd1 = 0;
    {s0_rs1, s0_rs2, s0_rd, s0_rs1_used, s0_rs2_used, s0_reg_write, s0_ctrl, s0_mem} = '0;
    {s1_rs1, s1_rs2, s1_rd, s1_rs1_used, s1_rs2_used, s1_reg_write, s1_ctrl, s1_mem} = '0;

    v = blank(); v.rst = 1;
    applyStimulus(v);
    applyStimulus(v);
    v = blank(); v.dv = 0;
    applyStimulus(v);

    // add x1,x2,x3 ; add x4,x5,x6
    v = blank();
    v.s[0] = mk(2, 3, 1, 1, 1, 1, 0, 0); v.s[1] = mk(5, 6, 4, 1, 1, 1, 0, 0);
    applyStimulus(v);

    // add x5,x1,x2 ; sub x6,x5,x3 -- split, then slot 1, then a fresh pair
    v = blank();
    v.s[0] = mk(1, 2, 5, 1, 1, 1, 0, 0); v.s[1] = mk(5, 3, 6, 1, 1, 1, 0, 0);
    applyStimulus(v);
    applyStimulus(v);
    v.s[1] = mk(7, 3, 6, 1, 1, 1, 0, 0);
    applyStimulus(v);

    // lw x7 in EX lane 1, slot 0 reads x7
    v = blank();
    v.s[0] = mk(7, 2, 8, 1, 1, 1, 0, 0); v.s[1] = mk(9, 10, 11, 1, 1, 1, 0, 0);
    v.exl1 = 1; v.exrd1 = 7;
    applyStimulus(v);
    v.exl1 = 0;
    applyStimulus(v);

    // beq taken in slot 0: split, redirect kills slot 1, flush, target pair
    v = blank();
    v.s[0] = mk(1, 2, 0, 1, 1, 0, 1, 0); v.s[1] = mk(3, 4, 5, 1, 1, 1, 0, 0);
    applyStimulus(v);
    v.redir = 1;
    applyStimulus(v);
    v.redir = 0;
    applyStimulus(v);
    v.s[0] = mk(2, 3, 1, 1, 1, 1, 0, 0);
    applyStimulus(v);

    // slot 0 writes x0, slot 1 reads x0 and also writes x0
    v = blank();
    v.s[0] = mk(1, 2, 0, 1, 1, 1, 0, 0); v.s[1] = mk(0, 0, 0, 1, 1, 1, 0, 0);
    applyStimulus(v);

    // reset while slot 1 is owed
    v = blank();
    v.s[0] = mk(1, 2, 5, 1, 1, 1, 0, 0); v.s[1] = mk(5, 3, 6, 1, 1, 1, 0, 0);
    applyStimulus(v);
    v.rst = 1;
    applyStimulus(v);
    v.rst = 0;
    applyStimulus(v);
    applyStimulus(v);

    for (int n = 0; n < 600; n++) begin
      v = '0;
      v.rst   = ($urandom_range(0, 49) == 0);
      v.redir = ($urandom_range(0, 9) == 0);
      v.dv    = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < 2; k++) begin
        v.s[k] = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
      end
      v.exl0  = ($urandom_range(0, 3) == 0);
      v.exl1  = ($urandom_range(0, 3) == 0);
      v.exrd0 = 5'($urandom_range(0, 7));
      v.exrd1 = 5'($urandom_range(0, 7));
      applyStimulus(v);
    end

    guard = 0;
    while (scoreQ.size() > 0 && guard < 10) begin
      @(posedge CLK);
      guard++;
    end
    if (scoreQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d responses outstanding, expected 0", scoreQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
